// File: rtl/sccb_slave_rx.sv
// sccb_slave_rx: SCCB/I2C write responder that ACKs its device address and emits register write pairs
module sccb_slave_rx #(
   parameter logic [6:0] DEV_ADDR    = 7'h21,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_data,
   output logic       wr_valid,
   output logic       busy,
   output logic       addr_nack
);
   typedef enum logic [2:0] {IDLE, DEVADR, REGADR, DATA, ACK, IGNORE} state_t;
   state_t state_q, state_d, ret_q, ret_d;
   logic [SYNC_STAGES:0] scl_q, scl_d, sda_q, sda_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic [7:0] shift_q, shift_d, reg_addr_q, reg_addr_d, reg_data_q, reg_data_d, byte_w;
   logic ack_ph_q, ack_ph_d, more_q, more_d, sda_oe_q, sda_oe_d;
   logic wr_valid_q, wr_valid_d, busy_q, busy_d, addr_nack_q, addr_nack_d;
   logic scl_s, scl_p, sda_s, sda_p, scl_rise, scl_fall, start, stop;
   // the extra top stage of each chain holds the previous synchronised sample for edge detection
   assign scl_s    = scl_q[SYNC_STAGES-1];
   assign scl_p    = scl_q[SYNC_STAGES];
   assign sda_s    = sda_q[SYNC_STAGES-1];
   assign sda_p    = sda_q[SYNC_STAGES];
   assign scl_rise = scl_s & ~scl_p;
   assign scl_fall = ~scl_s & scl_p;
   assign start    = scl_s & scl_p & sda_p & ~sda_s;
   assign stop     = scl_s & scl_p & ~sda_p & sda_s;
   assign byte_w   = {shift_q[6:0], sda_s};
   assign sda_oe    = sda_oe_q;
   assign reg_addr  = reg_addr_q;
   assign reg_data  = reg_data_q;
   assign wr_valid  = wr_valid_q;
   assign busy      = busy_q;
   assign addr_nack = addr_nack_q;
   // next-state: START/STOP override everything, ACK spans two SCL falls, bytes complete on the 8th rise
   always_comb begin
      scl_d       = {scl_q[SYNC_STAGES-1:0], scl_in};
      sda_d       = {sda_q[SYNC_STAGES-1:0], sda_in};
      state_d     = state_q;
      ret_d       = ret_q;
      bitcnt_d    = bitcnt_q;
      shift_d     = shift_q;
      ack_ph_d    = ack_ph_q;
      more_d      = more_q;
      sda_oe_d    = sda_oe_q;
      reg_addr_d  = reg_addr_q;
      reg_data_d  = reg_data_q;
      wr_valid_d  = 1'b0;
      addr_nack_d = 1'b0;
      busy_d      = busy_q;
      if (start) begin
         state_d  = DEVADR;
         bitcnt_d = 3'd0;
         busy_d   = 1'b1;
         sda_oe_d = 1'b0;
         ack_ph_d = 1'b0;
         more_d   = 1'b0;
      end else if (stop) begin
         state_d  = IDLE;
         busy_d   = 1'b0;
         sda_oe_d = 1'b0;
      end else if (state_q == ACK) begin
         if (scl_fall) begin
            sda_oe_d = ~ack_ph_q;
            ack_ph_d = ~ack_ph_q;
            state_d  = ack_ph_q ? ret_q : ACK;
            bitcnt_d = 3'd0;
         end
      end else if (scl_rise && (state_q == DEVADR || state_q == REGADR || state_q == DATA)) begin
         shift_d  = byte_w;
         bitcnt_d = bitcnt_q + 3'd1;
         if (bitcnt_q == 3'd7) begin
            ack_ph_d = 1'b0;
            ret_d    = (state_q == DEVADR) ? REGADR : DATA;
            state_d  = (state_q == DEVADR && byte_w != {DEV_ADDR, 1'b0}) ? IGNORE : ACK;
            addr_nack_d = (state_q == DEVADR && byte_w != {DEV_ADDR, 1'b0});
            if (state_q == REGADR) reg_addr_d = byte_w;
            if (state_q == DATA) begin
               reg_data_d = byte_w;
               reg_addr_d = more_q ? reg_addr_q + 8'd1 : reg_addr_q;
               more_d     = 1'b1;
               wr_valid_d = 1'b1;
            end
         end
      end
   end
   // state register; synchronisers preset to an idle (high) bus
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_q       <= '1;
         sda_q       <= '1;
         state_q     <= IDLE;
         ret_q       <= IDLE;
         bitcnt_q    <= '0;
         shift_q     <= '0;
         ack_ph_q    <= 1'b0;
         more_q      <= 1'b0;
         sda_oe_q    <= 1'b0;
         reg_addr_q  <= '0;
         reg_data_q  <= '0;
         wr_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
         addr_nack_q <= 1'b0;
      end else begin
         scl_q       <= scl_d;
         sda_q       <= sda_d;
         state_q     <= state_d;
         ret_q       <= ret_d;
         bitcnt_q    <= bitcnt_d;
         shift_q     <= shift_d;
         ack_ph_q    <= ack_ph_d;
         more_q      <= more_d;
         sda_oe_q    <= sda_oe_d;
         reg_addr_q  <= reg_addr_d;
         reg_data_q  <= reg_data_d;
         wr_valid_q  <= wr_valid_d;
         busy_q      <= busy_d;
         addr_nack_q <= addr_nack_d;
      end
   end
endmodule

// File: tb/tb_sccb_slave_rx.sv
// tb_sccb_slave_rx: bus-level master driving random SCCB write frames against a transaction model
module tb_sccb_slave_rx;
   localparam int Q = 6;
   logic clk = 1'b0, reset = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
   logic sda_oe, wr_valid, busy, addr_nack;
   logic [7:0] reg_addr, reg_data;
   logic sda_line;
   int total = 0, bad = 0, nack_cnt = 0;
   logic [15:0] wq[$];
   logic [15:0] eq[$];
   logic [7:0] fr[$];
   assign sda_line = sda_m & ~sda_oe;
   sccb_slave_rx dut (
      .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
      .reg_addr(reg_addr), .reg_data(reg_data), .wr_valid(wr_valid), .busy(busy), .addr_nack(addr_nack)
   );
   always #5 clk = ~clk;
   // passive monitor of write and nack pulses, sampled away from the active edge
   always @(negedge clk) begin
      if (wr_valid) wq.push_back({reg_addr, reg_data});
      if (addr_nack) nack_cnt++;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic qw(input int n);
      repeat (n) @(posedge clk);
   endtask
   task automatic send_start();
      sda_m = 1'b1; qw(Q); scl_m = 1'b1; qw(Q); sda_m = 1'b0; qw(Q); scl_m = 1'b0; qw(Q);
   endtask
   task automatic send_stop();
      sda_m = 1'b0; qw(Q); scl_m = 1'b1; qw(Q); sda_m = 1'b1; qw(Q);
   endtask
   task automatic send_bit(input logic b);
      sda_m = b; qw(Q); scl_m = 1'b1; qw(2 * Q); scl_m = 1'b0; qw(Q);
   endtask
   task automatic send_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      sda_m = 1'b1; qw(Q); scl_m = 1'b1; qw(Q);
      ack = sda_oe & ~sda_line;
      qw(Q); scl_m = 1'b0; qw(Q);
   endtask
   // model: only a 0x42 first byte is acked; data bytes land at reg address fr[1] + k (mod 256)
   task automatic run_frame(input bit do_stop);
      logic a;
      bit ok;
      int k0;
      k0 = nack_cnt;
      ok = (fr[0] == 8'h42);
      wq.delete();
      eq.delete();
      send_start();
      chk("busy_start", busy, 1);
      for (int i = 0; i < fr.size(); i++) begin
         send_byte(fr[i], a);
         chk($sformatf("ack%0d", i), a, ok);
         if (ok && i >= 2) eq.push_back({fr[1] + 8'(i - 2), fr[i]});
      end
      if (do_stop) begin
         send_stop();
         qw(4);
         chk("busy_end", busy, 0);
         chk("oe_end", sda_oe, 0);
      end
      chk("nacks", nack_cnt - k0, ok ? 0 : 1);
      chk("nwr", wq.size(), eq.size());
      for (int i = 0; i < eq.size() && i < wq.size(); i++) chk($sformatf("wr%0d", i), wq[i], eq[i]);
   endtask
   initial begin
      logic a;
      qw(3);
      #1;
      chk("rst_oe", sda_oe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wv", wr_valid, 0);
      chk("rst_nack", addr_nack, 0);
      chk("rst_addr", reg_addr, 0);
      chk("rst_data", reg_data, 0);
      reset = 1'b1;
      qw(5);
      fr = '{8'h42, 8'h12, 8'h80}; run_frame(1);
      fr = '{8'h44, 8'h12, 8'h80}; run_frame(1);
      fr = '{8'h43, 8'h01}; run_frame(1);
      fr = '{8'h42, 8'hFF, 8'h11, 8'h22}; run_frame(1);
      fr = '{8'h42, 8'h3A}; run_frame(0);
      fr = '{8'h42, 8'h05, 8'h07}; run_frame(1);
      // STOP in the middle of a data byte drops it
      wq.delete();
      send_start(); send_byte(8'h42, a); send_byte(8'h20, a);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      send_stop(); qw(4);
      chk("partial_nwr", wq.size(), 0);
      chk("partial_busy", busy, 0);
      // reset during data bit 4 clears everything at once
      send_start(); send_byte(8'h42, a); send_byte(8'h10, a); send_byte(8'h99, a);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      sda_m = 1'b1; qw(Q); scl_m = 1'b1; qw(2);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mrst_oe", sda_oe, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_addr", reg_addr, 0);
      chk("mrst_data", reg_data, 0);
      qw(3);
      reset = 1'b1;
      qw(Q);
      fr = '{8'h42, 8'h33, 8'h44}; run_frame(1);
      for (int f = 0; f < 20; f++) begin
         fr.delete();
         fr.push_back(($urandom_range(0, 3) != 0) ? 8'h42 : 8'($urandom_range(0, 255)));
         for (int i = 0, n = $urandom_range(0, 4); i < n; i++) fr.push_back(8'($urandom));
         run_frame(1);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
